// File: rtl/maze_walker_param_pkg.sv
// maze_pkg: shared headings, FSM states and turn helpers for the wall-follower maze walker.
package maze_pkg;
   typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_t;
   typedef enum logic [2:0] {IDLE, MARK, PROBE, EVAL, MOVE, DONE, FAIL} state_t;
   localparam logic HAND_RIGHT = 1'b0;
   localparam logic HAND_LEFT  = 1'b1;
   function automatic dir_t turn_right(dir_t d);
      return dir_t'(d + 2'd1);
   endfunction
   function automatic dir_t turn_left(dir_t d);
      return dir_t'(d - 2'd1);
   endfunction
   function automatic dir_t turn_back(dir_t d);
      return dir_t'(d + 2'd2);
   endfunction
   // try order: hand side, forward, opposite hand, back
   function automatic dir_t try_dir(dir_t d, logic hand, logic [1:0] k);
      return k == 2'd0 ? (hand == HAND_RIGHT ? turn_right(d) : turn_left(d)) :
             k == 2'd1 ? d :
             k == 2'd2 ? (hand == HAND_RIGHT ? turn_left(d) : turn_right(d)) : turn_back(d);
   endfunction
endpackage

// File: rtl/maze_walker_param_if.sv
// maze_walker_param_if: controller handshake and maze RAM port of the walker.
interface maze_walker_param_if #(
   parameter int ROW_W  = 6,
   parameter int COL_W  = 6,
   parameter int STEP_W = 16
);
   logic              start, hand, maze_in, maze_oe, maze_we, busy, done, fail;
   logic [1:0]        start_dir;
   logic [ROW_W-1:0]  starting_row, row;
   logic [COL_W-1:0]  starting_col, col;
   logic [STEP_W-1:0] steps;
   modport master (input start, hand, start_dir, starting_row, starting_col, maze_in,
                   output row, col, maze_oe, maze_we, busy, done, fail, steps);
   modport slave  (output start, hand, start_dir, starting_row, starting_col, maze_in,
                   input row, col, maze_oe, maze_we, busy, done, fail, steps);
endinterface

// File: rtl/maze_walker_param_neighbour.sv
// maze_neighbour: neighbour cell of (row,col) in a heading, with bounds and border flags.
module maze_neighbour import maze_pkg::*; #(
   parameter int ROWS  = 64,
   parameter int COLS  = 64,
   parameter int ROW_W = 6,
   parameter int COL_W = 6
) (
   input  logic [ROW_W-1:0] i_row,
   input  logic [COL_W-1:0] i_col,
   input  dir_t             i_dir,
   output logic [ROW_W-1:0] o_row,
   output logic [COL_W-1:0] o_col,
   output logic             o_in_bounds,
   output logic             o_on_border
);
   localparam logic [ROW_W:0]   R_ONE  = (ROW_W+1)'(1);
   localparam logic [ROW_W:0]   R_LIM  = (ROW_W+1)'(ROWS);
   localparam logic [ROW_W-1:0] R_LAST = ROW_W'(ROWS - 1);
   localparam logic [COL_W:0]   C_ONE  = (COL_W+1)'(1);
   localparam logic [COL_W:0]   C_LIM  = (COL_W+1)'(COLS);
   localparam logic [COL_W-1:0] C_LAST = COL_W'(COLS - 1);
   logic [ROW_W:0] w_r;
   logic [COL_W:0] w_c;
   // one extra bit so 0-1 wraps above the limit and last+1 lands on it
   assign w_r = i_dir == DIR_S ? {1'b0, i_row} + R_ONE :
                i_dir == DIR_N ? {1'b0, i_row} - R_ONE : {1'b0, i_row};
   assign w_c = i_dir == DIR_E ? {1'b0, i_col} + C_ONE :
                i_dir == DIR_W ? {1'b0, i_col} - C_ONE : {1'b0, i_col};
   assign o_row       = w_r[ROW_W-1:0];
   assign o_col       = w_c[COL_W-1:0];
   assign o_in_bounds = w_r < R_LIM && w_c < C_LIM;
   assign o_on_border = o_row == '0 || o_row == R_LAST || o_col == '0 || o_col == C_LAST;
endmodule

// File: rtl/maze_walker_param.sv
// maze_walker_param: wall-follower maze solver driving a synchronous maze RAM.
module maze_walker_param import maze_pkg::*; #(
   parameter int ROWS      = 64,
   parameter int COLS      = 64,
   parameter int MAX_STEPS = 4096,
   parameter int STEP_W    = 16
) (
   input logic clk,
   input logic rst_n,
   maze_walker_param_if.master bus
);
   localparam int ROW_W = $clog2(ROWS);
   localparam int COL_W = $clog2(COLS);
   localparam logic [STEP_W-1:0] LIMIT = STEP_W'(MAX_STEPS);
   state_t            r_state;
   dir_t              r_dir;
   logic              r_hand, r_oe, r_we, r_busy, r_done, r_fail, r_bord, r_exit;
   logic [1:0]        r_k;
   logic [ROW_W-1:0]  r_cur_row, r_start_row, r_row;
   logic [COL_W-1:0]  r_cur_col, r_start_col, r_col;
   logic [STEP_W-1:0] r_steps;
   dir_t              w_tdir [2];
   logic [ROW_W-1:0]  w_nrow [2];
   logic [COL_W-1:0]  w_ncol [2];
   logic [1:0]        w_ib, w_bd;
   // lane 0 looks at the current try, lane 1 at the next one, so outputs stay registered
   for (genvar j = 0; j < 2; j++) begin : g_nbr
      assign w_tdir[j] = try_dir(r_dir, r_hand, r_k + 2'(j));
      maze_neighbour #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) u_nbr (
         .i_row(r_cur_row), .i_col(r_cur_col), .i_dir(w_tdir[j]),
         .o_row(w_nrow[j]), .o_col(w_ncol[j]), .o_in_bounds(w_ib[j]), .o_on_border(w_bd[j]));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_dir <= DIR_N;
         {r_hand, r_oe, r_we, r_busy, r_done, r_fail, r_bord, r_exit} <= '0;
         r_k <= '0;
         {r_cur_row, r_start_row, r_row} <= '0;
         {r_cur_col, r_start_col, r_col} <= '0;
         r_steps <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.start) begin
               {r_cur_row, r_start_row, r_row} <= {3{bus.starting_row}};
               {r_cur_col, r_start_col, r_col} <= {3{bus.starting_col}};
               r_dir <= dir_t'(bus.start_dir);
               r_hand <= bus.hand;
               {r_done, r_fail, r_steps, r_k} <= '0;
               {r_busy, r_we} <= 2'b11;
               r_state <= MARK;
            end
            MARK: begin
               r_we <= 1'b0;
               {r_row, r_col, r_oe, r_bord} <= {w_nrow[0], w_ncol[0], w_ib[0], w_bd[0]};
               r_state <= PROBE;
            end
            PROBE: if (r_oe) begin
               r_oe <= 1'b0;
               r_state <= EVAL;
            end else if (r_k == 2'd3) begin
               {r_fail, r_busy} <= 2'b10;
               r_state <= FAIL;
            end else begin
               r_k <= r_k + 2'd1;
               {r_row, r_col, r_oe, r_bord} <= {w_nrow[1], w_ncol[1], w_ib[1], w_bd[1]};
            end
            EVAL: if (!bus.maze_in) begin
               {r_cur_row, r_cur_col} <= {r_row, r_col};
               r_dir <= w_tdir[0];
               r_k <= '0;
               r_steps <= r_steps + STEP_W'(r_steps != '1);
               r_exit <= r_bord && (r_row != r_start_row || r_col != r_start_col);
               r_we <= 1'b1;
               r_state <= MOVE;
            end else if (r_k == 2'd3) begin
               {r_fail, r_busy} <= 2'b10;
               r_state <= FAIL;
            end else begin
               r_k <= r_k + 2'd1;
               {r_row, r_col, r_oe, r_bord} <= {w_nrow[1], w_ncol[1], w_ib[1], w_bd[1]};
               r_state <= PROBE;
            end
            MOVE: begin
               r_we <= 1'b0;
               if (r_exit) begin
                  {r_done, r_busy} <= 2'b10;
                  r_state <= DONE;
               end else if (r_steps == LIMIT) begin
                  {r_fail, r_busy} <= 2'b10;
                  r_state <= FAIL;
               end else begin
                  {r_row, r_col, r_oe, r_bord} <= {w_nrow[0], w_ncol[0], w_ib[0], w_bd[0]};
                  r_state <= PROBE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.row     = r_row;
   assign bus.col     = r_col;
   assign bus.maze_oe = r_oe;
   assign bus.maze_we = r_we;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.fail    = r_fail;
   assign bus.steps   = r_steps;
endmodule
